pc_ctrl_ras: RTL and testbench

//  Parametrised program-counter sequencer for the stack CPU, with an internal return-address stack (RAS).

---
 rtl/pc_ctrl_ras.sv | 183 ++++++++++++++++++
 tb/tb_pc_ctrl_ras.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl_ras.sv
// Program-counter sequencer for the stack CPU with an internal return-address
// stack. One control op per en strobe; branch targets come from the data-stack
// top. RAS over/underflow and out-of-range targets end in a sticky fault.
module pc_ctrl_ras #(
  parameter  int INST_CAP  = 20,
  parameter  int DATA_LEN  = 8,
  parameter  int RAS_DEPTH = 4,
  parameter  int WRAP      = 0,
  localparam int PC_W      = $clog2(INST_CAP),
  localparam int LVL_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [3:0]          op,
  input  logic [DATA_LEN-1:0] target,
  input  logic                z_flag,
  input  logic                s_flag,
  output logic [PC_W-1:0]     pc,
  output logic                tgt_pop,
  output logic                done,
  output logic                busy,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [LVL_W-1:0]    ras_level
);

  // Wide enough that pc + sign-extended offset never overflows.
  localparam int XW = PC_W + DATA_LEN + 1;

  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JS   = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_JREL = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_EVAL, S_HALT, S_FAULT} state_t;

  state_t              state, state_nx;
  logic [3:0]          op_q, op_nx;
  logic [PC_W-1:0]     ras [RAS_DEPTH];
  logic [PC_W-1:0]     nxt, pc_nx, eval_pc;
  logic [XW-1:0]       tgt_u;
  logic signed [XW-1:0] rel;
  logic                taken, range_bad, push;
  logic [1:0]          flt, code_nx;
  logic [LVL_W-2:0]    push_idx, pop_idx;
  logic                done_nx, pop_nx, halted_nx, fault_nx;
  logic [LVL_W-1:0]    lvl_nx;

  assign nxt      = (pc == PC_W'(INST_CAP - 1)) ? ((WRAP != 0) ? '0 : pc) : pc + PC_W'(1);
  assign tgt_u    = XW'(target);
  assign rel      = $signed(XW'(pc)) + $signed({{(XW-DATA_LEN){target[DATA_LEN-1]}}, target});
  assign push_idx = ras_level[LVL_W-2:0];
  assign pop_idx  = push_idx - (LVL_W-1)'(1);

  // Branch resolution and fault classification for the op held in EVAL.
  always_comb begin
    taken     = 1'b1;
    range_bad = (tgt_u >= XW'(INST_CAP));
    eval_pc   = target[PC_W-1:0];
    flt       = 2'b00;
    case (op_q)
      OP_JZ:   taken = z_flag;
      OP_JS:   taken = s_flag;
      OP_JNZ:  taken = !z_flag;
      OP_JREL: begin
        range_bad = rel[XW-1] || ($unsigned(rel) >= XW'(INST_CAP));
        eval_pc   = rel[PC_W-1:0];
      end
      OP_RET: begin
        range_bad = 1'b0;
        eval_pc   = ras[pop_idx];
      end
      default: ;
    endcase
    if (!taken) eval_pc = nxt;
    // Overflow outranks the range check on a CALL.
    if (op_q == OP_CALL && ras_level == LVL_W'(RAS_DEPTH)) flt = 2'b01;
    else if (op_q == OP_RET && ras_level == '0)             flt = 2'b10;
    else if (taken && range_bad)                            flt = 2'b11;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; HALT and FAULT are only left through reset.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (en) begin
        if (op < OP_JMP)        state_nx = S_EXEC;
        else if (op == OP_HALT) state_nx = S_HALT;
        else                    state_nx = S_EVAL;
      end
      S_EXEC:  state_nx = S_IDLE;
      S_EVAL:  state_nx = (flt != 2'b00) ? S_FAULT : S_IDLE;
      default: state_nx = state;
    endcase
  end

  // Output/datapath next values; a fault leaves pc, RAS and done untouched.
  always_comb begin
    pc_nx     = pc;
    done_nx   = 1'b0;
    pop_nx    = 1'b0;
    halted_nx = halted;
    fault_nx  = fault;
    code_nx   = fault_code;
    lvl_nx    = ras_level;
    op_nx     = op_q;
    push      = 1'b0;
    case (state)
      S_IDLE: if (en) begin
        op_nx  = op;
        pop_nx = (op >= OP_JMP) && (op != OP_RET) && (op != OP_HALT);
        if (op == OP_HALT) begin
          done_nx   = 1'b1;
          halted_nx = 1'b1;
        end
      end
      S_EXEC: begin
        pc_nx   = nxt;
        done_nx = 1'b1;
      end
      S_EVAL: begin
        if (flt != 2'b00) begin
          fault_nx  = 1'b1;
          halted_nx = 1'b1;
          code_nx   = flt;
        end else begin
          pc_nx   = eval_pc;
          done_nx = 1'b1;
          if (op_q == OP_CALL) begin
            push   = 1'b1;
            lvl_nx = ras_level + LVL_W'(1);
          end else if (op_q == OP_RET) begin
            lvl_nx = ras_level - LVL_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc         <= '0;
      done       <= 1'b0;
      tgt_pop    <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      ras_level  <= '0;
      op_q       <= '0;
    end else begin
      pc         <= pc_nx;
      done       <= done_nx;
      tgt_pop    <= pop_nx;
      busy       <= (state_nx != S_IDLE);
      halted     <= halted_nx;
      fault      <= fault_nx;
      fault_code <= code_nx;
      ras_level  <= lvl_nx;
      op_q       <= op_nx;
    end
  end

  // RAS storage; emptiness is tracked by ras_level alone.
  always_ff @(posedge clk) begin
    if (push) ras[push_idx] <= nxt;
  end

endmodule

// File: tb/tb_pc_ctrl_ras.sv
// Randomised and directed bench for pc_ctrl_ras against a queue-based model.
module tb_pc_ctrl_ras;
  localparam int CAP = 20, DL = 8, DEPTH = 4, WRAP = 0, PCW = 5, LW = 3;

  logic           clk = 1'b0, rstn = 1'b0, en = 1'b0, z_flag = 1'b0, s_flag = 1'b0;
  logic [3:0]     op = 4'h0;
  logic [DL-1:0]  target = '0;
  logic [PCW-1:0] pc;
  logic           tgt_pop, done, busy, halted, fault;
  logic [1:0]     fault_code;
  logic [LW-1:0]  ras_level;

  pc_ctrl_ras #(.INST_CAP(CAP), .DATA_LEN(DL), .RAS_DEPTH(DEPTH), .WRAP(WRAP)) dut (
    .clk(clk), .rstn(rstn), .en(en), .op(op), .target(target), .z_flag(z_flag),
    .s_flag(s_flag), .pc(pc), .tgt_pop(tgt_pop), .done(done), .busy(busy),
    .halted(halted), .fault(fault), .fault_code(fault_code), .ras_level(ras_level)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: architectural state only.
  int m_pc, m_code;
  int m_ras[$];
  bit m_halt, m_fault;

  // Results of the last exec call.
  int r_pops, e_pops;
  bit r_d1, r_d2, r_b1, e_ok;

  task automatic model_reset();
    m_pc = 0; m_ras.delete(); m_halt = 0; m_fault = 0; m_code = 0;
  endtask

  task automatic model_step(input logic [3:0] o, input logic [7:0] t, input bit z, input bit s);
    int nxt, r;
    bit tk;
    nxt   = (m_pc == CAP-1) ? (WRAP ? 0 : CAP-1) : m_pc + 1;
    e_ok  = 1;
    e_pops = (o >= 4'h8 && o != 4'hD && o != 4'hF) ? 1 : 0;
    if (o < 4'h8) m_pc = nxt;
    else case (o)
      4'h8, 4'h9, 4'hA, 4'hB: begin
        tk = (o == 4'h8) || (o == 4'h9 && z) || (o == 4'hA && s) || (o == 4'hB && !z);
        if (!tk) m_pc = nxt;
        else if (int'(t) >= CAP) begin e_ok = 0; m_code = 3; end
        else m_pc = int'(t);
      end
      4'hC: begin
        if (m_ras.size() == DEPTH) begin e_ok = 0; m_code = 1; end
        else if (int'(t) >= CAP)   begin e_ok = 0; m_code = 3; end
        else begin m_ras.push_back(nxt); m_pc = int'(t); end
      end
      4'hD: begin
        if (m_ras.size() == 0) begin e_ok = 0; m_code = 2; end
        else m_pc = m_ras.pop_back();
      end
      4'hE: begin
        r = m_pc + int'($signed(t));
        if (r < 0 || r >= CAP) begin e_ok = 0; m_code = 3; end
        else m_pc = r;
      end
      default: m_halt = 1;
    endcase
    if (!e_ok) begin m_fault = 1; m_halt = 1; end
  endtask

  // Drive one op starting at a negedge; samples the two cycles that follow.
  task automatic exec(input logic [3:0] o, input logic [7:0] t, input bit z, input bit s);
    model_step(o, t, z, s);
    op = o; target = t; z_flag = z; s_flag = s; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    r_pops = int'(tgt_pop); r_d1 = done; r_b1 = busy;
    @(negedge clk);
    r_pops += int'(tgt_pop); r_d2 = done;
  endtask

  task automatic do_reset();
    en = 1'b0;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    checks++;
    if ({pc, done, tgt_pop, busy, halted, fault, fault_code, ras_level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pc=%0d done=%b pop=%b busy=%b halted=%b fault=%b code=%b lvl=%0d required all 0",
               pc, done, tgt_pop, busy, halted, fault, fault_code, ras_level);
    end
    @(negedge clk); rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_seq();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      exec(4'h1, 8'h0, 0, 0);
      checks++;
      if (r_d1 !== 1'b0 || r_d2 !== 1'b1) begin
        errors++; $display("FAIL seq_done_timing[%0d]: got %b%b required 01", i, r_d1, r_d2);
      end
      checks++;
      if (int'(pc) !== i) begin
        errors++; $display("FAIL seq_pc[%0d]: got %0d required %0d", i, pc, i);
      end
      // One idle cycle gives the 2-cycle strobe spacing.
    end
  endtask

  task automatic test_wrap();
    exec(4'h8, 8'd19, 0, 0);
    exec(4'h3, 8'h0, 0, 0);
    checks++;
    if (int'(pc) !== 19 || int'(pc) !== m_pc || r_d2 !== 1'b1) begin
      errors++; $display("FAIL wrap_saturate: got pc=%0d done=%b required pc=19 done=1", pc, r_d2);
    end
  endtask

  task automatic test_jz();
    do_reset();
    exec(4'h9, 8'd12, 1, 0);
    checks++;
    if (r_pops !== 1 || int'(pc) !== 12) begin
      errors++; $display("FAIL jz_taken: got pops=%0d pc=%0d required pops=1 pc=12", r_pops, pc);
    end
    exec(4'h9, 8'd12, 0, 0);
    checks++;
    if (r_pops !== 1 || int'(pc) !== 13) begin
      errors++; $display("FAIL jz_not_taken: got pops=%0d pc=%0d required pops=1 pc=13", r_pops, pc);
    end
  endtask

  task automatic test_call_ret();
    int exp_ret [4] = '{8, 7, 6, 3};
    do_reset();
    exec(4'h8, 8'd2, 0, 0);
    for (int i = 5; i <= 8; i++) exec(4'hC, 8'(i), 0, 0);
    checks++;
    if (int'(ras_level) !== 4 || int'(pc) !== 8) begin
      errors++; $display("FAIL call_fill: got lvl=%0d pc=%0d required lvl=4 pc=8", ras_level, pc);
    end
    for (int i = 0; i < 4; i++) begin
      exec(4'hD, 8'h0, 0, 0);
      checks++;
      if (int'(pc) !== exp_ret[i] || int'(ras_level) !== 3 - i) begin
        errors++; $display("FAIL ret_pop[%0d]: got pc=%0d lvl=%0d required pc=%0d lvl=%0d",
                           i, pc, ras_level, exp_ret[i], 3 - i);
      end
    end
    for (int i = 0; i < 5; i++) exec(4'hC, 8'd10, 0, 0);
    checks++;
    if (fault_code !== 2'b01 || halted !== 1'b1 || int'(ras_level) !== 4 || r_d2 !== 1'b0) begin
      errors++; $display("FAIL ras_overflow: got code=%b halted=%b lvl=%0d done=%b required 01 1 4 0",
                         fault_code, halted, ras_level, r_d2);
    end
    do_reset();
    exec(4'hD, 8'h0, 0, 0);
    checks++;
    if (fault_code !== 2'b10 || fault !== 1'b1 || pc !== '0) begin
      errors++; $display("FAIL ras_underflow: got code=%b fault=%b pc=%0d required 10 1 0", fault_code, fault, pc);
    end
  endtask

  task automatic test_range();
    do_reset();
    exec(4'h8, 8'd25, 0, 0);
    checks++;
    if (fault_code !== 2'b11 || pc !== '0 || r_pops !== 1) begin
      errors++; $display("FAIL jmp_range: got code=%b pc=%0d pops=%0d required 11 0 1", fault_code, pc, r_pops);
    end
    do_reset();
    exec(4'h8, 8'd5, 0, 0);
    exec(4'hE, 8'hFD, 0, 0);
    checks++;
    if (int'(pc) !== 2 || fault !== 1'b0) begin
      errors++; $display("FAIL jrel_back: got pc=%0d fault=%b required pc=2 fault=0", pc, fault);
    end
    do_reset();
    exec(4'h8, 8'd5, 0, 0);
    exec(4'hE, 8'hF0, 0, 0);
    checks++;
    if (fault_code !== 2'b11 || int'(pc) !== 5) begin
      errors++; $display("FAIL jrel_range: got code=%b pc=%0d required 11 5", fault_code, pc);
    end
  endtask

  task automatic test_reset_mid_halt();
    int dcnt;
    do_reset();
    exec(4'hC, 8'd4, 0, 0);
    op = 4'h8; target = 8'd9; en = 1'b1;
    @(negedge clk); en = 1'b0;
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (pc !== '0 || tgt_pop !== 1'b0 || ras_level !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_eval: got pc=%0d pop=%b lvl=%0d busy=%b required all 0",
                         pc, tgt_pop, ras_level, busy);
    end
    @(negedge clk); rstn = 1'b1; model_reset();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pc !== '0) begin
      errors++; $display("FAIL reset_no_complete: got done=%b pc=%0d required 0 0", done, pc);
    end
    exec(4'hF, 8'h0, 0, 0);
    dcnt = int'(r_d1) + int'(r_d2);
    for (int i = 0; i < 3; i++) begin @(negedge clk); dcnt += int'(done); end
    checks++;
    if (dcnt !== 1 || halted !== 1'b1 || fault !== 1'b0) begin
      errors++; $display("FAIL halt_entry: got dones=%0d halted=%b fault=%b required 1 1 0", dcnt, halted, fault);
    end
    op = 4'h1; en = 1'b1; dcnt = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); dcnt += int'(done); end
    en = 1'b0;
    checks++;
    if (dcnt !== 0 || pc !== '0 || halted !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL halt_ignores_en: got dones=%0d pc=%0d halted=%b busy=%b required 0 0 1 1",
                         dcnt, pc, halted, busy);
    end
  endtask

  task automatic test_back_to_back();
    int dcnt = 0;
    do_reset();
    op = 4'h2; en = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); dcnt += int'(done); end
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (int'(pc) !== 3 || dcnt !== 3) begin
      errors++; $display("FAIL back_to_back: got pc=%0d dones=%0d required pc=3 dones=3", pc, dcnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] o;
    logic [7:0] t;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      if (m_halt) do_reset();
      o = 4'($urandom_range(0, 15));
      if (o == 4'hE)                    t = 8'($urandom_range(0, 12) - 6);
      else if ($urandom_range(0, 4) == 0) t = 8'($urandom_range(0, 255));
      else                              t = 8'($urandom_range(0, CAP - 1));
      exec(o, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (int'(pc) !== m_pc || int'(ras_level) !== m_ras.size()) begin
        errors++; $display("FAIL rand_state[%0d] op=%h t=%0d: got pc=%0d lvl=%0d required pc=%0d lvl=%0d",
                           n, o, t, pc, ras_level, m_pc, m_ras.size());
      end
      checks++;
      if (fault !== m_fault || int'(fault_code) !== m_code || halted !== m_halt) begin
        errors++; $display("FAIL rand_flags[%0d] op=%h: got fault=%b code=%0d halted=%b required %b %0d %b",
                           n, o, fault, fault_code, halted, m_fault, m_code, m_halt);
      end
      checks++;
      if (r_pops !== e_pops || r_b1 !== 1'b1) begin
        errors++; $display("FAIL rand_pop_busy[%0d] op=%h: got pops=%0d busy=%b required %0d 1",
                           n, o, r_pops, r_b1, e_pops);
      end
      checks++;
      if (o == 4'hF ? (int'(r_d1) + int'(r_d2) !== 1)
                    : (r_d1 !== 1'b0 || r_d2 !== e_ok)) begin
        errors++; $display("FAIL rand_done[%0d] op=%h: got %b%b ok=%b", n, o, r_d1, r_d2, e_ok);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq();
    test_wrap();
    test_jz();
    test_call_ret();
    test_range();
    test_reset_mid_halt();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
